sd_mag_scheduler: RTL and testbench

Time-multiplexes one shared sigma-delta magnitude estimator across CHANNELS sigma-delta bitstreams. On each scan it steps through the enabled channels in order, routes one bitstream to the estimator, resets it, waits a settle period, then peak-holds the estimator output over a measurement window. Each channel's peak is delivered on a valid/ready result port. The block sits between the modulator bitstream inputs and the single estimator instance, and owns that estimator's reset and enable.

---
 rtl/sd_mag_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_sd_mag_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_mag_scheduler.sv
// sd_mag_scheduler
// Shares one sigma-delta magnitude estimator across CHANNELS bitstreams.
// A scan walks the channels enabled in the latched mask in ascending order.
// For each channel the estimator is reset, allowed to settle, and then its
// output is peak-held over a measurement window. The peak is offered on a
// valid/ready result port.
//
// Ports:
//   clk, rstN          clock, synchronous active-low reset
//   en                 time-base enable for CLR/SETTLE/MEAS
//   start, chMask      scan request (IDLE only) and channel mask
//   sdIn, sdSel        bitstreams in, selected bitstream out (combinational)
//   estRst, estEn      estimator reset (active high) and clock enable
//   estOut             estimator magnitude
//   resValid/resReady  result handshake; resChan/resData carry the result
//   busy, done         scan in progress, one-cycle end-of-scan pulse
module sd_mag_scheduler #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int SETTLE   = 256,
  parameter int WINDOW   = 1024,
  parameter int CHW      = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                en,
  input  logic                start,
  input  logic [CHANNELS-1:0] chMask,
  input  logic [CHANNELS-1:0] sdIn,
  output logic                sdSel,
  output logic                estRst,
  output logic                estEn,
  input  logic [WIDTH-1:0]    estOut,
  output logic                resValid,
  input  logic                resReady,
  output logic [CHW-1:0]      resChan,
  output logic [WIDTH-1:0]    resData,
  output logic                busy,
  output logic                done
);

  // One counter serves CLR, SETTLE and MEAS; it is cleared on every state entry.
  localparam int MAXC = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int CNTW = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);
  localparam logic [CNTW-1:0] WINDOW_LAST = CNTW'(WINDOW - 1);
  localparam logic [CNTW-1:0] CLR_LAST    = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_ONE     = CNTW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    SETTLE_ST = 3'd2,
    MEAS   = 3'd3,
    REPORT = 3'd4,
    NEXT   = 3'd5
  } state_t;

  state_t              state_r;
  logic [CHW-1:0]      cur_chan_r;
  logic [CHANNELS-1:0] mask_r;
  logic [CNTW-1:0]     cnt_r;
  logic [WIDTH-1:0]    peak_r;

  logic [CHW:0]        first_s;
  logic [CHW:0]        next_s;
  logic [WIDTH-1:0]    peak_next_s;

  // Lowest set bit of m at index >= lo. MSB of the result flags a hit,
  // the low CHW bits hold the index.
  function automatic logic [CHW:0] find_from(input logic [CHANNELS-1:0] m, input int lo);
    logic [CHW:0] r;
    r = {(CHW + 1){1'b0}};
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) begin
        r = {1'b1, CHW'(i)};
      end
    end
    return r;
  endfunction

  assign first_s     = find_from(chMask, 0);
  assign next_s      = find_from(mask_r, int'(cur_chan_r) + 1);
  assign peak_next_s = (estOut > peak_r) ? estOut : peak_r;
  assign sdSel       = sdIn[cur_chan_r];

  // Scan sequencer with all outputs (except sdSel) registered.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_r    <= IDLE;
      cur_chan_r <= {CHW{1'b0}};
      mask_r     <= {CHANNELS{1'b0}};
      cnt_r      <= {CNTW{1'b0}};
      peak_r     <= {WIDTH{1'b0}};
      resValid   <= 1'b0;
      resChan    <= {CHW{1'b0}};
      resData    <= {WIDTH{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      estEn      <= 1'b0;
      estRst     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          estRst     <= 1'b0;
          estEn      <= 1'b0;
          cur_chan_r <= {CHW{1'b0}};
          if (start) begin
            mask_r <= chMask;
            if (first_s[CHW]) begin
              state_r    <= CLR;
              cur_chan_r <= first_s[CHW-1:0];
              cnt_r      <= {CNTW{1'b0}};
              estRst     <= 1'b1;
              busy       <= 1'b1;
            end else begin
              // Empty mask: the scan is over before it began.
              done <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CLR: begin
          peak_r <= {WIDTH{1'b0}};
          estEn  <= 1'b0;
          if (en) begin
            if (cnt_r == CLR_LAST) begin
              state_r <= SETTLE_ST;
              cnt_r   <= {CNTW{1'b0}};
              estRst  <= 1'b0;
              estEn   <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            state_r <= CLR;
          end
        end
        SETTLE_ST: begin
          estEn <= en;
          if (en) begin
            if (cnt_r == SETTLE_LAST) begin
              state_r <= MEAS;
              cnt_r   <= {CNTW{1'b0}};
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            state_r <= SETTLE_ST;
          end
        end
        MEAS: begin
          estEn <= en;
          if (en) begin
            peak_r <= peak_next_s;
            if (cnt_r == WINDOW_LAST) begin
              // The last window sample is folded straight into the result.
              state_r  <= REPORT;
              resValid <= 1'b1;
              resChan  <= cur_chan_r;
              resData  <= peak_next_s;
              estEn    <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            state_r <= MEAS;
          end
        end
        REPORT: begin
          estEn <= 1'b0;
          if (resReady) begin
            state_r  <= NEXT;
            resValid <= 1'b0;
          end else begin
            state_r <= REPORT;
          end
        end
        NEXT: begin
          if (next_s[CHW]) begin
            state_r    <= CLR;
            cur_chan_r <= next_s[CHW-1:0];
            cnt_r      <= {CNTW{1'b0}};
            estRst     <= 1'b1;
          end else begin
            state_r    <= IDLE;
            cur_chan_r <= {CHW{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          cur_chan_r <= {CHW{1'b0}};
          resValid   <= 1'b0;
          busy       <= 1'b0;
          estEn      <= 1'b0;
          estRst     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_mag_scheduler.sv
module tb_sd_mag_scheduler;
  localparam int CH  = 4;
  localparam int W   = 16;
  localparam int S   = 4;
  localparam int WN  = 8;
  localparam int CHW = 2;

  logic          clk = 1'b0;
  logic          rstN, en, start, resReady;
  logic [CH-1:0] chMask, sdIn;
  logic          sdSel, estRst, estEn, resValid, busy, done;
  logic [W-1:0]  estOut, resData;
  logic [CHW-1:0] resChan;

  always #5 clk = ~clk;

  sd_mag_scheduler #(.CHANNELS(CH), .WIDTH(W), .SETTLE(S), .WINDOW(WN), .CHW(CHW)) dut (
    .clk(clk), .rstN(rstN), .en(en), .start(start), .chMask(chMask), .sdIn(sdIn),
    .sdSel(sdSel), .estRst(estRst), .estEn(estEn), .estOut(estOut),
    .resValid(resValid), .resReady(resReady), .resChan(resChan), .resData(resData),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [W-1:0]   data;
  } res_t;
  res_t sb_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One full scan with a cycle-accurate expectation model derived from the
  // enabled-edge count: CLR = enabled edges 1..2, SETTLE 3..S+2, MEAS S+3..S+WN+2.
  task automatic run_scan(input logic [CH-1:0] mask, input int hold_low, input bit toggle_en,
                          input bit ramp, input bit poke_start, input bit check_s1);
    logic [CHW-1:0] chans[$];
    int e, guard;
    logic [W-1:0] peak;
    bit last_en;
    res_t exp_r;
    for (int i = 0; i < CH; i++) if (mask[i]) chans.push_back(CHW'(i));
    chMask = mask; start = 1'b1; en = 1'b1; resReady = 1'b0; estOut = 16'd0;
    sdIn = 4'($urandom);
    cyc = 0;
    tick();
    start = 1'b0; chMask = 4'($urandom);
    if (chans.size() == 0) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || estRst !== 1'b0)
        $display("FAIL empty_done cyc=%0d done=%b busy=%b estRst=%b required 1 0 0", cyc, done, busy, estRst);
      if (done !== 1'b1 || busy !== 1'b0 || estRst !== 1'b0) errors++;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || estRst !== 1'b0) begin
        errors++;
        $display("FAIL empty_after done=%b busy=%b estRst=%b required 0 0 0", done, busy, estRst);
      end
      return;
    end
    foreach (chans[k]) begin
      e = 0; peak = 16'd0; last_en = 1'b1; guard = 0;
      while (1) begin
        checks++;
        if (resValid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || estRst !== (e < 2) ||
            estEn !== ((e >= 2) && last_en)) begin
          errors++;
          $display("FAIL scan_ctl ch=%0d cyc=%0d e=%0d resValid=%b busy=%b done=%b estRst=%b estEn=%b required 0 1 0 %b %b",
                   chans[k], cyc, e, resValid, busy, done, estRst, estEn, (e < 2), ((e >= 2) && last_en));
        end
        en = toggle_en ? ((cyc % 2) == 1) : 1'b1;
        if (ramp) estOut = 16'(cyc);
        else estOut = en ? 16'($urandom_range(0, 32767)) : 16'hFFFF;
        sdIn = 4'($urandom);
        start = poke_start && ($urandom_range(0, 3) == 0);
        chMask = 4'($urandom);
        #1;
        checks++;
        if (sdSel !== sdIn[chans[k]]) begin
          errors++;
          $display("FAIL sdsel ch=%0d cyc=%0d got=%b required=%b", chans[k], cyc, sdSel, sdIn[chans[k]]);
        end
        tick();
        start = 1'b0;
        last_en = en;
        if (en) begin
          e++;
          if (e >= S + 3 && e <= S + WN + 2 && estOut > peak) peak = estOut;
        end
        if (e == S + WN + 2) break;
        guard++;
        if (guard > 200) begin
          checks++; errors++;
          $display("FAIL timeout ch=%0d e=%0d required %0d", chans[k], e, S + WN + 2);
          return;
        end
      end
      exp_r.ch = chans[k]; exp_r.data = peak;
      sb_q.push_back(exp_r);
      if (check_s1) begin
        checks++;
        if (cyc != 15 || resValid !== 1'b1 || resData !== 16'd14) begin
          errors++;
          $display("FAIL s1_result cyc=%0d resValid=%b resData=%0d required cyc 15 valid 1 data 14", cyc, resValid, resData);
        end
      end
      for (int h = 0; h <= hold_low; h++) begin
        resReady = (h == hold_low);
        en = 1'($urandom_range(0, 1));
        checks++;
        if (resValid !== 1'b1 || resChan !== sb_q[0].ch || resData !== sb_q[0].data ||
            busy !== 1'b1 || estEn !== 1'b0 || estRst !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL report h=%0d valid=%b chan=%0d data=%0h busy=%b estEn=%b estRst=%b done=%b required 1 %0d %0h 1 0 0 0",
                   h, resValid, resChan, resData, busy, estEn, estRst, done, sb_q[0].ch, sb_q[0].data);
        end
        tick();
      end
      void'(sb_q.pop_front());
      resReady = 1'b0;
      checks++;
      if (resValid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || estRst !== 1'b0) begin
        errors++;
        $display("FAIL next_state valid=%b busy=%b done=%b estRst=%b required 0 1 0 0", resValid, busy, done, estRst);
      end
      en = 1'b1;
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || resValid !== 1'b0 || estRst !== 1'b0 || (check_s1 && cyc != 17)) begin
      errors++;
      $display("FAIL scan_done cyc=%0d done=%b busy=%b valid=%b estRst=%b required 1 0 0 0", cyc, done, busy, resValid, estRst);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_once done=%b busy=%b required 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; en = 1'b0; start = 1'b0; resReady = 1'b0; chMask = 4'd0; sdIn = 4'd0; estOut = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (resValid !== 1'b0 || resChan !== 2'd0 || resData !== 16'd0 || busy !== 1'b0 ||
        done !== 1'b0 || estEn !== 1'b0 || estRst !== 1'b1) begin
      errors++;
      $display("FAIL reset_vals valid=%b chan=%0d data=%0h busy=%b done=%b estEn=%b estRst=%b required 0 0 0 0 0 0 1",
               resValid, resChan, resData, busy, done, estEn, estRst);
    end
    rstN = 1'b1;
    tick();
    checks++;
    if (estRst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release estRst=%b busy=%b required 0 0", estRst, busy);
    end
  endtask

  task automatic test_single_ramp();
    run_scan(4'b0001, 0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_two_chan();
    run_scan(4'b1010, 0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back_backpressure();
    run_scan(4'b1100, 20, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_en_toggle();
    run_scan(4'b0001, 0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_meas();
    chMask = 4'b0100; start = 1'b1; en = 1'b1; resReady = 1'b1; estOut = 16'h7777;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rstN = 1'b0;
    tick();
    checks++;
    if (resValid !== 1'b0 || resChan !== 2'd0 || resData !== 16'd0 || busy !== 1'b0 ||
        done !== 1'b0 || estEn !== 1'b0 || estRst !== 1'b1) begin
      errors++;
      $display("FAIL midreset valid=%b chan=%0d data=%0h busy=%b done=%b estEn=%b estRst=%b required 0 0 0 0 0 0 1",
               resValid, resChan, resData, busy, done, estEn, estRst);
    end
    rstN = 1'b1;
    sb_q.delete();
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (resValid !== 1'b0 || busy !== 1'b0 || estRst !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL post_reset i=%0d valid=%b busy=%b estRst=%b done=%b required 0 0 0 0", i, resValid, busy, estRst, done);
      end
    end
    resReady = 1'b0;
    run_scan(4'b0001, 0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_empty_mask();
    run_scan(4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_ramp();
    test_two_chan();
    test_back_to_back_backpressure();
    test_en_toggle();
    test_reset_mid_meas();
    test_empty_mask();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
